seq_detector: RTL and testbench

Parametrised, run-time programmable symbol-sequence detector for the sequential-circuit test set. It accepts a stream of SYM_W-bit symbols and raises a one-cycle `match` pulse each time the last `len` accepted symbols equal a programmed pattern. It also keeps a saturating match counter.

- Length, pattern and overlap mode are loaded at run time.
- It is the generalised successor of the fixed 2-bit, fixed-pattern Moore detectors in this test set.

---
 rtl/seq_det_pkg.sv | 22 ++
 rtl/sym_window.sv | 45 ++++
 rtl/seq_detector.sv | 115 +++++++++++
 tb/tb_seq_detector.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared helpers and mode constants for the symbol-sequence detector
package seq_det_pkg;

    localparam logic OVL_ON  = 1'b1;
    localparam logic OVL_OFF = 1'b0;

    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // A zero length would make the comparator vacuous, so it is promoted to one symbol.
    function automatic int clamp_len(input int raw, input int max_len);
        if (raw <= 0) begin
            return 1;
        end
        if (raw > max_len) begin
            return max_len;
        end
        return raw;
    endfunction

endpackage

// File: rtl/sym_window.sv
// rtl/sym_window.sv - SYM_W x MAX_LEN symbol shift register, newest symbol at position len-1
module sym_window #(
    parameter int SYM_W   = 2,
    parameter int MAX_LEN = 4,
    parameter int LEN_W   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_shift,
    input  logic                     i_clr,
    input  logic [LEN_W-1:0]         i_len,
    input  logic [SYM_W-1:0]         i_sym,
    output logic [MAX_LEN*SYM_W-1:0] o_win_next
);

    logic [MAX_LEN*SYM_W-1:0] r_win;
    logic [MAX_LEN*SYM_W-1:0] w_next;

    // Positions at or above len are left untouched; only the low len slots form the window.
    always_comb begin
        w_next = r_win;
        if (i_clr) begin
            w_next = '0;
        end else if (i_shift) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if (i + 1 < int'(i_len)) begin
                    w_next[i*SYM_W +: SYM_W] = r_win[(i+1)*SYM_W +: SYM_W];
                end else if (i + 1 == int'(i_len)) begin
                    w_next[i*SYM_W +: SYM_W] = i_sym;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win <= '0;
        end else begin
            r_win <= w_next;
        end
    end

    assign o_win_next = w_next;

endmodule

// File: rtl/seq_detector.sv
// rtl/seq_detector.sv - run-time programmable symbol-sequence detector with saturating match counter
module seq_detector
    import seq_det_pkg::*;
#(
    parameter  int SYM_W   = 2,
    parameter  int MAX_LEN = 4,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = len_w(MAX_LEN)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [SYM_W-1:0]         sym,
    input  logic                     cfg_load,
    input  logic [LEN_W-1:0]         cfg_len,
    input  logic [MAX_LEN*SYM_W-1:0] cfg_pattern,
    input  logic                     cfg_overlap,
    input  logic                     cnt_clr,
    output logic                     armed,
    output logic                     match,
    output logic [LEN_W-1:0]         fill,
    output logic [CNT_W-1:0]         match_count
);

    logic [LEN_W-1:0]         r_len;
    logic [MAX_LEN*SYM_W-1:0] r_pat;
    logic                     r_ovl;
    logic                     r_armed;
    logic                     r_match;
    logic [LEN_W-1:0]         r_fill;
    logic [CNT_W-1:0]         r_cnt;

    logic                     w_accept;
    logic [LEN_W-1:0]         w_fill_inc;
    logic                     w_full;
    logic                     w_pat_eq;
    logic                     w_hit;
    logic [MAX_LEN*SYM_W-1:0] w_win_next;

    // A symbol arriving on the same edge as cfg_load is dropped.
    assign w_accept = in_valid & ~cfg_load;

    sym_window #(
        .SYM_W   (SYM_W),
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_window (
        .clk        (clk),
        .rst        (reset),
        .i_shift    (w_accept),
        .i_clr      (cfg_load),
        .i_len      (r_len),
        .i_sym      (sym),
        .o_win_next (w_win_next)
    );

    assign w_fill_inc = (r_fill < r_len) ? r_fill + LEN_W'(1) : r_len;
    assign w_full     = (w_fill_inc == r_len);

    always_comb begin
        w_pat_eq = 1'b1;
        for (int k = 0; k < MAX_LEN; k++) begin
            if (k < int'(r_len) &&
                w_win_next[k*SYM_W +: SYM_W] != r_pat[k*SYM_W +: SYM_W]) begin
                w_pat_eq = 1'b0;
            end
        end
    end

    assign w_hit = w_accept & r_armed & w_full & w_pat_eq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len   <= LEN_W'(1);
            r_pat   <= '0;
            r_ovl   <= OVL_ON;
            r_armed <= 1'b0;
            r_match <= 1'b0;
            r_fill  <= '0;
        end else if (cfg_load) begin
            r_len   <= LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));
            r_pat   <= cfg_pattern;
            r_ovl   <= cfg_overlap;
            r_armed <= 1'b1;
            r_match <= 1'b0;
            r_fill  <= '0;
        end else if (w_accept) begin
            r_match <= w_hit;
            // Non-overlapping mode restarts the count so the next match needs len fresh symbols.
            if (w_hit && r_ovl == OVL_OFF) begin
                r_fill <= '0;
            end else begin
                r_fill <= w_fill_inc;
            end
        end else begin
            r_match <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_hit && r_cnt != {CNT_W{1'b1}}) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign armed       = r_armed;
    assign match       = r_match;
    assign fill        = r_fill;
    assign match_count = r_cnt;

endmodule

// File: tb/tb_seq_detector.sv
// tb/tb_seq_detector.sv - randomized and directed self-checking bench for seq_detector
module tb_seq_detector;

    localparam int SYM_W   = 2;
    localparam int MAX_LEN = 4;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = 3;
    localparam int CNT_MAX = 3;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     in_valid;
    logic [SYM_W-1:0]         sym;
    logic                     cfg_load;
    logic [LEN_W-1:0]         cfg_len;
    logic [MAX_LEN*SYM_W-1:0] cfg_pattern;
    logic                     cfg_overlap;
    logic                     cnt_clr;
    logic                     armed;
    logic                     match;
    logic [LEN_W-1:0]         fill;
    logic [CNT_W-1:0]         match_count;

    int n_checks = 0;
    int n_errors = 0;
    int pulses   = 0;

    int m_len, m_pat, m_fill, m_count;
    bit m_ovl, m_armed, m_match;
    int hist[$];

    seq_detector #(
        .SYM_W   (SYM_W),
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .sym         (sym),
        .cfg_load    (cfg_load),
        .cfg_len     (cfg_len),
        .cfg_pattern (cfg_pattern),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .armed       (armed),
        .match       (match),
        .fill        (fill),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pat4(input int e0, input int e1, input int e2, input int e3);
        return e0 | (e1 << 2) | (e2 << 4) | (e3 << 6);
    endfunction

    task automatic model_reset();
        m_len = 1; m_pat = 0; m_ovl = 1'b1; m_armed = 1'b0;
        m_match = 1'b0; m_fill = 0; m_count = 0;
        hist.delete();
    endtask

    // The last len accepted symbols (since the last clear) must equal the low len pattern elements.
    function automatic bit tail_matches();
        if (hist.size() < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            if (hist[hist.size() - m_len + k] != ((m_pat >> (2 * k)) & 3)) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_edge(input bit v, input int s, input bit ld, input int ln,
                              input int pt, input bit ov, input bit clr);
        bit hit;
        hit = 1'b0;
        if (ld) begin
            m_len   = (ln == 0) ? 1 : (ln > MAX_LEN ? MAX_LEN : ln);
            m_pat   = pt;
            m_ovl   = ov;
            m_armed = 1'b1;
            m_fill  = 0;
            m_match = 1'b0;
            hist.delete();
        end else if (v) begin
            hist.push_back(s);
            if (hist.size() > 8) void'(hist.pop_front());
            m_fill = (m_fill + 1 > m_len) ? m_len : m_fill + 1;
            hit = m_armed && (m_fill == m_len) && tail_matches();
            if (hit && !m_ovl) m_fill = 0;
            m_match = hit;
        end else begin
            m_match = 1'b0;
        end
        if (clr) m_count = 0;
        else if (hit && m_count < CNT_MAX) m_count++;
    endtask

    task automatic step(input bit v, input int s, input bit ld, input int ln,
                        input int pt, input bit ov, input bit clr);
        @(negedge clk);
        in_valid    = v;
        sym         = SYM_W'(s);
        cfg_load    = ld;
        cfg_len     = LEN_W'(ln);
        cfg_pattern = 8'(pt);
        cfg_overlap = ov;
        cnt_clr     = clr;
        @(posedge clk);
        model_edge(v, s, ld, ln, pt, ov, clr);
        #1;
        chk("match", int'(match), int'(m_match));
        chk("fill", int'(fill), m_fill);
        chk("count", int'(match_count), m_count);
        chk("armed", int'(armed), int'(m_armed));
        pulses += int'(match);
    endtask

    task automatic feed(input int s);
        step(1'b1, s, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic load(input int ln, input int pt, input bit ov, input bit clr);
        step(1'b0, 0, 1'b1, ln, pt, ov, clr);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; sym = '0; cfg_load = 1'b0;
        cfg_len = '0; cfg_pattern = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_match", int'(match), 0);
        chk("rst_fill", int'(fill), 0);
        chk("rst_count", int'(match_count), 0);
        chk("rst_armed", int'(armed), 0);
        @(negedge clk);
        reset = 1'b0;

        // unarmed stream never matches; len 0 clamps to 1
        feed(0); feed(0); feed(0);
        chk("unarmed_pulses", pulses, 0);
        load(0, 0, 1'b1, 1'b0);
        feed(0);
        chk("len0_match", int'(match), 1);

        load(3, pat4(1, 2, 3, 0), 1'b1, 1'b1);
        pulses = 0;
        feed(0); feed(1); feed(2); feed(3); feed(1); feed(2); feed(3);
        chk("p123_pulses", pulses, 2);
        chk("p123_count", int'(match_count), 2);

        load(2, pat4(1, 1, 0, 0), 1'b1, 1'b1);
        pulses = 0;
        repeat (4) feed(1);
        chk("ovl_pulses", pulses, 3);
        load(2, pat4(1, 1, 0, 0), 1'b0, 1'b1);
        pulses = 0;
        repeat (4) feed(1);
        chk("novl_pulses", pulses, 2);

        // cfg_load with a symbol mid-pattern drops it
        load(3, pat4(1, 2, 3, 0), 1'b1, 1'b0);
        feed(1); feed(2);
        step(1'b1, 3, 1'b1, 3, pat4(1, 2, 3, 0), 1'b1, 1'b0);
        chk("drop_fill", int'(fill), 0);
        feed(3);
        chk("drop_nomatch", int'(match), 0);
        load(7, pat4(0, 1, 2, 3), 1'b1, 1'b0);
        feed(0); feed(1); feed(2); feed(3);
        chk("len7_match", int'(match), 1);
        chk("len7_fill", int'(fill), 4);

        load(1, pat4(2, 0, 0, 0), 1'b1, 1'b1);
        repeat (5) feed(2);
        chk("sat_count", int'(match_count), 3);
        step(1'b1, 2, 1'b0, 0, 0, 1'b0, 1'b1);
        chk("clr_count", int'(match_count), 0);
        chk("clr_match", int'(match), 1);

        // asynchronous reset between edges while fill=2
        load(3, pat4(1, 2, 3, 0), 1'b1, 1'b0);
        feed(1); feed(2);
        chk("pre_rst_fill", int'(fill), 2);
        #2 reset = 1'b1;
        #1;
        chk("arst_match", int'(match), 0);
        chk("arst_fill", int'(fill), 0);
        chk("arst_count", int'(match_count), 0);
        chk("arst_armed", int'(armed), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        feed(1); feed(2); feed(3);
        chk("post_rst_pulses", pulses, 0);

        for (int i = 0; i < 600; i++) begin
            bit v, ld, ov, clr;
            int ln, pt;
            v   = ($urandom_range(0, 3) != 0);
            ld  = ($urandom_range(0, 39) == 0);
            clr = ($urandom_range(0, 29) == 0);
            ov  = $urandom_range(0, 1);
            ln  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(1, 2);
            pt  = $urandom_range(0, 255);
            step(v, $urandom_range(0, 3), ld, ln, pt, ov, clr);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
